mac_stream_agen: RTL
====================

MAC_STREAM_AGEN -- requirements
Module: mac_stream_agen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the word and line counters.
REQ-003 SHALL have parameter WORD_BYTES, default 4, byte increment per word.
REQ-004 SHALL have port clk_i  in  1  clock, rising edge.
REQ-005 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clear_i  in  1  synchronous clear to IDLE.
REQ-007 SHALL have port req_start_i  in  1  start request from the controlling FSM.
REQ-008 SHALL have port base_addr_i  in  ADDR_WIDTH  first byte address.
REQ-009 SHALL have port trans_size_i  in  CNT_WIDTH  total words to emit.
REQ-010 SHALL have port line_length_i  in  CNT_WIDTH  words per line.
REQ-011 SHALL have port line_stride_i  in  ADDR_WIDTH  byte step between line bases (0 = contiguous).
REQ-012 SHALL have port ready_start_o  out  1  block can accept req_start_i.
REQ-013 SHALL have port done_o  out  1  one-cycle completion pulse.
REQ-014 SHALL have port addr_o / addr_valid_o / addr_ready_i  out/out/in  ADDR_WIDTH/1/1  address stream.
REQ-015 SHALL have port cnt_o  out  CNT_WIDTH  words accepted so far.
REQ-016 SHALL have port error_o  out  1  misalignment flag (see Configuration).

Function
REQ-017 SHALL implement states IDLE, RUN, DONE.
REQ-018 SHALL assert ready_start_o only in IDLE.
- IDLE -> RUN: req_start_i=1 and trans_size_i!=0.
- IDLE -> DONE: req_start_i=1 and trans_size_i==0.
REQ-019 SHALL latch all config inputs on the accepting req_start_i cycle; later input changes SHALL have no effect until the next start.
REQ-020 SHALL ignore req_start_i in RUN and DONE.
REQ-021 SHALL assert addr_valid_o from the first RUN cycle, with addr_o = latched base (latency 1 cycle from req_start_i).
REQ-022 SHALL hold addr_valid_o high and addr_o stable until addr_valid_o&addr_ready_i.
REQ-023 SHALL on each handshake increment cnt_o and advance the address:
- within a line: addr += WORD_BYTES.
- at word index line_length-1, when line_stride!=0: line base += line_stride, addr = new line base, word index = 0.
- when line_stride==0: addr += WORD_BYTES (contiguous).
- line_length==0 SHALL be treated as line_length = trans_size.
REQ-024 SHALL on the handshake where cnt_o reaches trans_size-1 drop addr_valid_o next cycle and go to DONE.
REQ-025 SHALL pulse done_o for exactly the single DONE cycle, then return to IDLE.
REQ-026 SHALL wrap address arithmetic modulo 2^ADDR_WIDTH with no flag.
REQ-027 SHALL on clear_i=1 in any state go to IDLE next cycle:
- addr_valid_o, done_o, cnt_o, error_o = 0.
- clear_i SHALL take priority over req_start_i and handshakes.

Reset
REQ-028 SHALL on rst_ni=0 asynchronously force state IDLE, addr_o=0, addr_valid_o=0, done_o=0, cnt_o=0, error_o=0; ready_start_o=1 while in reset and after release.

Configuration
REQ-029 SHALL honour macro MAC_STREAM_AGEN_MISALIGN_CHK_EN.
- Defined: a start with base_addr_i or line_stride_i not a multiple of WORD_BYTES SHALL go to DONE without emitting addresses, set error_o=1 (sticky until next accepted start or clear_i), and still pulse done_o.
- Undefined: no check; error_o tied 0; addresses emitted as given.

Structure
REQ-030 SHALL take the state enum (state_agen_t) and agen ctrl/flags struct typedefs from mac_package; no local copies.
REQ-031 SHALL instantiate one sub-module, mac_stream_agen_cnt: word/line counter pair with line-wrap output.

Verification
REQ-032 Base 0x1000, trans 4, line 4, stride 0, ready always 1 -> addrs 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles; done_o 1 cycle after last; cnt_o=4.
REQ-033 Base 0x2000, trans 6, line 2, stride 0x100 -> addrs 0x2000, 0x2004, 0x2100, 0x2104, 0x2200, 0x2204.
REQ-034 addr_ready_i toggling 1/0 -> addr_o stable while stalled; 4 handshakes total; done_o single pulse.
REQ-035 trans_size 0 -> no addr_valid_o; done_o 1 cycle after req_start_i; ready_start_o back high the cycle after that.
REQ-036 clear_i after 2 handshakes of trans 8 -> IDLE next cycle, cnt_o=0, no done_o; a new start then behaves normally.
REQ-037 Macro defined, base 0x1002 -> error_o=1, done_o pulse, zero addresses; macro undefined, same base -> addrs 0x1002, 0x1006, ....

Source files
------------

// File: rtl/mac_package.sv
// Shared types for the MAC stream address generator: FSM state, control strobes and output flags.
package mac_package;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_agen_t;

  typedef struct packed {
    logic start;
    logic clear;
    logic step;
  } agen_ctrl_t;

  typedef struct packed {
    logic valid;
    logic done;
    logic error;
  } agen_flags_t;

endpackage

// File: rtl/mac_stream_agen_cnt.sv
// Word-in-line index and total accepted-word counter.
// line_wrap flags the last word of the current line.
module mac_stream_agen_cnt #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 step,
  input  logic [CNT_WIDTH-1:0] line_len,
  output logic [CNT_WIDTH-1:0] total,
  output logic                 line_wrap
);

  logic [CNT_WIDTH-1:0] word_idx;

  assign line_wrap = (word_idx == line_len - CNT_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_idx <= '0;
      total    <= '0;
    end else if (clear) begin
      word_idx <= '0;
      total    <= '0;
    end else if (step) begin
      total    <= total + CNT_WIDTH'(1);
      word_idx <= line_wrap ? '0 : word_idx + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/mac_stream_agen.sv
// Strided/line-based byte-address stream generator with start/done handshake.
// Optional misalignment check enabled by defining MAC_STREAM_AGEN_MISALIGN_CHK_EN.
module mac_stream_agen
  import mac_package::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  req_start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  trans_size_i,
  input  logic [CNT_WIDTH-1:0]  line_length_i,
  input  logic [ADDR_WIDTH-1:0] line_stride_i,
  output logic                  ready_start_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  addr_valid_o,
  input  logic                  addr_ready_i,
  output logic [CNT_WIDTH-1:0]  cnt_o,
  output logic                  error_o
);

  state_agen_t           state;
  agen_ctrl_t            ctrl;
  agen_flags_t           flags;
  logic [ADDR_WIDTH-1:0] addr, line_base, stride;
  logic [CNT_WIDTH-1:0]  trans_size, line_len, cnt;
  logic                  line_wrap;
  logic                  misaligned;

`ifdef MAC_STREAM_AGEN_MISALIGN_CHK_EN
  assign misaligned = ((base_addr_i % ADDR_WIDTH'(WORD_BYTES)) != '0) ||
                      ((line_stride_i % ADDR_WIDTH'(WORD_BYTES)) != '0);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    ctrl       = '0;
    ctrl.clear = clear_i;
    ctrl.start = (state == IDLE) && req_start_i && !clear_i;
    ctrl.step  = (state == RUN) && flags.valid && addr_ready_i && !clear_i;
  end

  mac_stream_agen_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .clear     (ctrl.clear | ctrl.start),
    .step      (ctrl.step),
    .line_len  (line_len),
    .total     (cnt),
    .line_wrap (line_wrap)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      addr       <= '0;
      line_base  <= '0;
      stride     <= '0;
      trans_size <= '0;
      line_len   <= '0;
      flags      <= '0;
    end else if (ctrl.clear) begin
      state <= IDLE;
      flags <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl.start) begin
            trans_size <= trans_size_i;
            // A zero line length means the whole transfer is one line.
            line_len   <= (line_length_i == '0) ? trans_size_i : line_length_i;
            stride     <= line_stride_i;
            line_base  <= base_addr_i;
            addr       <= base_addr_i;
            if (misaligned) begin
              state <= DONE;
              flags <= '{valid: 1'b0, done: 1'b1, error: 1'b1};
            end else if (trans_size_i == '0) begin
              state <= DONE;
              flags <= '{valid: 1'b0, done: 1'b1, error: 1'b0};
            end else begin
              state <= RUN;
              flags <= '{valid: 1'b1, done: 1'b0, error: 1'b0};
            end
          end
        end
        RUN: begin
          if (ctrl.step) begin
            if (cnt == trans_size - CNT_WIDTH'(1)) begin
              state       <= DONE;
              flags.valid <= 1'b0;
              flags.done  <= 1'b1;
            end else if (line_wrap && (stride != '0)) begin
              line_base <= line_base + stride;
              addr      <= line_base + stride;
            end else begin
              addr <= addr + ADDR_WIDTH'(WORD_BYTES);
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          flags.done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_start_o = (state == IDLE);
  assign done_o        = flags.done;
  assign addr_o        = addr;
  assign addr_valid_o  = flags.valid;
  assign cnt_o         = cnt;
  assign error_o       = flags.error;

endmodule
